xadac_vdot: RTL and testbench
=============================

Name: xadac_vdot

Overview:
- Execute-stage unit directly downstream of decode/issue. Consumes ExeReqT beats and returns ExeRspT beats.
- Computes a length-masked 8-bit-lane dot product of vs_data[0] and vs_data[1]. Accumulates onto rs_data[0] and writes the result to scalar rd.
- Two-stage elastic pipeline with valid/ready on both sides; one result per cycle at full throughput.

Parameters:
- NoLanes, VecDataWidth/VecElemWidth (16), number of 8-bit lanes per vector operand.
- PipeStages, 2, fixed; informational only (not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high, clears all pipeline valids.
- req_valid  in  1  ExeReqT beat valid.
- req_ready  out  1  unit can accept a beat this cycle.
- req  in  $bits(ExeReqT)  id, instr, rs_addr/rs_data[2], vs_addr/vs_data[3].
- rsp_valid  out  1  ExeRspT beat valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp  out  $bits(ExeRspT)  id, rd_addr/rd_data/rd_write, vd_addr/vd_data/vd_write.

Behaviour:
- Op decode on instr[14:12]: 3'b000 = VDOT.U (unsigned lanes), 3'b001 = VDOT.S (two's-complement lanes). Any other value is illegal.
- Active length: len = rs_data[1][VecLenWidth-1:0], clamped to 16 (values 17..31 treated as 16). Lane i (element bits [8i+7:8i]) contributes only if i < len. len = 0 means the sum is rs_data[0].
- Stage 1, on accept (req_valid && req_ready):
  - Registers 16 products p_i = a_i*b_i (16-bit; signed or unsigned per op), masked to 0 for inactive lanes.
  - Also registers id, rd_addr = instr[11:7], acc = rs_data[0], op and legal flag.
- Stage 2: reduction tree. Products are sign- or zero-extended to 32 bits and summed with acc modulo 2^32; the result is registered into rsp.
- Latency: a beat accepted in cycle N yields rsp_valid in cycle N+2 when there is no backpressure.
- Response fields:
  - Legal op: rd_write=1, rd_data=sum.
  - Illegal op: rd_write=0, rd_data=0, still responded with the same id.
  - Always: vd_write=0, vd_addr=0, vd_data=0.
- Flow control:
  - stall = rsp_valid && !rsp_ready. On stall, both stages hold their contents.
  - req_ready = !stall || !s1_valid, so a bubble in stage 1 can be filled while stage 2 is stalled. Stage 1 advances into stage 2 only when stage 2 is empty or draining.
  - req_ready has no combinational dependency on req_valid.
- Order: responses are in strict acceptance order. No beat is dropped or duplicated.
- rsp is stable while rsp_valid && !rsp_ready.
- Simultaneous accept and drain in the same cycle: full throughput, no bubble.
- Reset mid-operation: all valids go to 0 asynchronously and in-flight beats are discarded. After reset: rsp_valid=0, rsp=0, req_ready=1 from the first cycle after deassertion.

Optional Feature:
- XADAC_VDOT_SAT_EN defined: stage 2 computes at 34-bit width, then saturates.
  - VDOT.S clamps to [0x80000000, 0x7FFFFFFF]; acc is interpreted signed.
  - VDOT.U clamps to 0xFFFFFFFF; acc is interpreted unsigned.
- Undefined: plain modulo-2^32 wrap. Latency is unchanged in both builds.

Decomposition:
- Shared package gains:
  - VdotOpT enum: VDOT_U=3'b000, VDOT_S=3'b001.
  - VdotProdT (16-bit) and NoLanes.
  - Funct3 field position constants.
- One sub-module: xadac_vdot_lane. Single-lane 8x8 multiply with signed/unsigned select and active mask; instantiated 16 times in stage 1.

Test Plan:
- VDOT.U, all lanes a=b=0xFF, len=16, acc=0 -> rd_data=16*65025=0x000FE010, rd_write=1, rsp_valid 2 cycles after accept.
- VDOT.S, a=0xFF(-1), b=0x02, len=4, acc=10 -> rd_data=2 (10-8), same id echoed, rd_addr=instr[11:7].
- len=0 gives rd_data=acc. len=31 gives the same result as len=16. funct3=3'b111 -> rd_write=0, rd_data=0, id echoed.
- Back-to-back 8 beats with rsp_ready=1 -> 8 responses on consecutive cycles, ids in order. Then hold rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0 once both stages are full, and no loss on release.
- Wrap versus saturation: VDOT.U, acc=0xFFFFFFF0, a=b=0x04, len=2 (+32) -> 0x00000010 without the macro, 0xFFFFFFFF with XADAC_VDOT_SAT_EN.
- Assert rst while two beats are in flight -> rsp_valid drops immediately, no stale response after reset, and the next accepted beat returns correctly.

Source files
------------

// File: rtl/xadac_vdot_pkg.sv
// xadac_vdot_pkg: shared types and constants for the xadac vector dot-product execute unit.
// Holds the execute request/response beat structs, the VDOT op encoding,
// the lane product type and the instruction field positions.
package xadac_vdot_pkg;

   localparam int unsigned IdWidth      = 8;
   localparam int unsigned InstrWidth   = 32;
   localparam int unsigned XLen         = 32;
   localparam int unsigned RegAddrWidth = 5;
   localparam int unsigned VecDataWidth = 128;
   localparam int unsigned VecElemWidth = 8;
   localparam int unsigned NoLanes      = VecDataWidth / VecElemWidth;
   localparam int unsigned VecLenWidth  = 5;
   localparam int unsigned ProdWidth    = 16;
   localparam int unsigned SumWidth     = 32;
   localparam int unsigned SatSumWidth  = 34;
   localparam int unsigned PipeStages   = 2;

   // Instruction field positions
   localparam int unsigned Funct3Lsb = 12;
   localparam int unsigned Funct3Msb = 14;
   localparam int unsigned RdLsb     = 7;
   localparam int unsigned RdMsb     = 11;

   typedef enum logic [2:0] {
      VDOT_U = 3'b000,
      VDOT_S = 3'b001
   } VdotOpT;

   typedef logic [ProdWidth-1:0] VdotProdT;

   typedef struct packed {
      logic [IdWidth-1:0]                     id;
      logic [InstrWidth-1:0]                  instr;
      logic [1:0][RegAddrWidth-1:0]           rs_addr;
      logic [1:0][XLen-1:0]                   rs_data;
      logic [2:0][RegAddrWidth-1:0]           vs_addr;
      logic [2:0][VecDataWidth-1:0]           vs_data;
   } ExeReqT;

   typedef struct packed {
      logic [IdWidth-1:0]      id;
      logic [RegAddrWidth-1:0] rd_addr;
      logic [XLen-1:0]         rd_data;
      logic                    rd_write;
      logic [RegAddrWidth-1:0] vd_addr;
      logic [VecDataWidth-1:0] vd_data;
      logic                    vd_write;
   } ExeRspT;

   // Stage-1 pipeline register contents
   typedef struct packed {
      logic [IdWidth-1:0]      id;
      logic [RegAddrWidth-1:0] rdAddr;
      logic [XLen-1:0]         acc;
      logic                    isSigned;
      logic                    legal;
      VdotProdT [NoLanes-1:0]  prod;
   } VdotS1T;

   localparam int unsigned ReqWidth = $bits(ExeReqT);
   localparam int unsigned RspWidth = $bits(ExeRspT);

   function automatic logic isLegalOp(input logic [2:0] funct3);
      return (funct3 == VDOT_U) || (funct3 == VDOT_S);
   endfunction

endpackage

// File: rtl/xadac_vdot_lane.sv
// xadac_vdot_lane: one 8x8 lane multiply with signed/unsigned select and lane mask.
// Ports: a, b       - lane elements
//        isSigned   - treat elements as two's complement
//        active     - lane lies inside the active length; otherwise product is 0
//        prodC      - 16-bit product (combinational)
module xadac_vdot_lane
   import xadac_vdot_pkg::*;
(
   input  logic [VecElemWidth-1:0] a,
   input  logic [VecElemWidth-1:0] b,
   input  logic                    isSigned,
   input  logic                    active,
   output VdotProdT                prodC
);

   logic [ProdWidth-1:0] aExt;
   logic [ProdWidth-1:0] bExt;

   // Low 16 bits of the product of extended operands are exact for both signednesses
   assign aExt  = {{(ProdWidth-VecElemWidth){isSigned & a[VecElemWidth-1]}}, a};
   assign bExt  = {{(ProdWidth-VecElemWidth){isSigned & b[VecElemWidth-1]}}, b};
   assign prodC = active ? VdotProdT'(aExt * bExt) : '0;

endmodule

// File: rtl/xadac_vdot.sv
// xadac_vdot: two-stage elastic execute unit computing a length-masked 8-bit-lane
// dot product of vs_data[0] and vs_data[1], accumulated onto rs_data[0] and
// written to scalar rd.
// Ports: clk, rst (async, active-high)
//        req_valid/req_ready/req : ExeReqT request beats
//        rsp_valid/rsp_ready/rsp : ExeRspT response beats (registered)
// Build option: XADAC_VDOT_SAT_EN - saturate the sum instead of wrapping modulo 2^32.
module xadac_vdot
   import xadac_vdot_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ReqWidth-1:0] req,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [RspWidth-1:0] rsp
);

   ExeReqT                 reqS;
   logic [2:0]             funct3C;
   logic [VecLenWidth-1:0] lenC;
   VdotProdT [NoLanes-1:0] laneProd;
   VdotS1T                 s1NextC;
   VdotS1T                 s1Q;
   logic                   s1Valid;
   ExeRspT                 rspNextC;
   ExeRspT                 rspQ;
   logic                   stallC;
   logic [SumWidth-1:0]    sumC;
   logic                   unusedBits;

   assign reqS    = req;
   assign funct3C = reqS.instr[Funct3Msb:Funct3Lsb];
   assign lenC    = reqS.rs_data[1][VecLenWidth-1:0];

   assign unusedBits = ^{reqS.instr[InstrWidth-1:Funct3Msb+1], reqS.instr[RdLsb-1:0],
                         reqS.rs_addr, reqS.rs_data[1][XLen-1:VecLenWidth],
                         reqS.vs_addr, reqS.vs_data[2]};

   // Stage 2 holds while its result is not taken; stage 1 may still fill a bubble
   assign stallC    = rsp_valid && !rsp_ready;
   assign req_ready = !stallC || !s1Valid;

   // Lane multipliers; lengths 17..31 enable every lane since lane index < 16
   for (genvar i = 0; i < NoLanes; i++) begin : gLane
      xadac_vdot_lane uLane (
         .a        (reqS.vs_data[0][i*VecElemWidth +: VecElemWidth]),
         .b        (reqS.vs_data[1][i*VecElemWidth +: VecElemWidth]),
         .isSigned (funct3C == VDOT_S),
         .active   (lenC > VecLenWidth'(i)),
         .prodC    (laneProd[i])
      );
   end

   // Stage-1 capture
   always_comb begin
      s1NextC          = '0;
      s1NextC.id       = reqS.id;
      s1NextC.rdAddr   = reqS.instr[RdMsb:RdLsb];
      s1NextC.acc      = reqS.rs_data[0];
      s1NextC.isSigned = (funct3C == VDOT_S);
      s1NextC.legal    = isLegalOp(funct3C);
      s1NextC.prod     = laneProd;
   end

   // Stage-2 reduction
`ifdef XADAC_VDOT_SAT_EN
   logic [SatSumWidth-1:0] wideC;

   always_comb begin
      wideC = {{(SatSumWidth-SumWidth){s1Q.isSigned & s1Q.acc[XLen-1]}}, s1Q.acc};
      for (int i = 0; i < NoLanes; i++) begin
         wideC = wideC + {{(SatSumWidth-ProdWidth){s1Q.isSigned & s1Q.prod[i][ProdWidth-1]}},
                          s1Q.prod[i]};
      end
      sumC = wideC[SumWidth-1:0];
      if (s1Q.isSigned) begin
         // Signed overflow when the top bits disagree; the MSB gives the direction
         if (wideC[SatSumWidth-1:SumWidth-1] != {(SatSumWidth-SumWidth+1){wideC[SatSumWidth-1]}})
            sumC = wideC[SatSumWidth-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         if (wideC[SatSumWidth-1:SumWidth] != '0)
            sumC = 32'hFFFF_FFFF;
      end
   end
`else
   always_comb begin
      sumC = s1Q.acc;
      for (int i = 0; i < NoLanes; i++) begin
         sumC = sumC + {{(SumWidth-ProdWidth){s1Q.isSigned & s1Q.prod[i][ProdWidth-1]}},
                        s1Q.prod[i]};
      end
   end
`endif

   // Response formation; illegal ops still answer with their id
   always_comb begin
      rspNextC          = '0;
      rspNextC.id       = s1Q.id;
      rspNextC.rd_addr  = s1Q.rdAddr;
      rspNextC.rd_write = s1Q.legal;
      rspNextC.rd_data  = s1Q.legal ? sumC : '0;
   end

   // Pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid   <= 1'b0;
         s1Q       <= '0;
         rsp_valid <= 1'b0;
         rspQ      <= '0;
      end else begin
         if (req_ready) begin
            s1Valid <= req_valid;
            if (req_valid) s1Q <= s1NextC;
         end
         if (!stallC) begin
            rsp_valid <= s1Valid;
            if (s1Valid) rspQ <= rspNextC;
         end
      end
   end

   assign rsp = rspQ;

endmodule

// File: tb/tb_xadac_vdot.sv
// tb_xadac_vdot: directed self-checking bench for xadac_vdot.
// Drives and samples on the falling clock edge; expected values are hand-computed.
// Build option: XADAC_VDOT_SAT_EN selects the saturating expectations.
module tb_xadac_vdot;
   import xadac_vdot_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   logic   req_valid;
   logic   req_ready;
   ExeReqT reqV;
   logic   rsp_valid;
   logic   rsp_ready;
   ExeRspT rspV;

   int nChecks = 0;
   int nBad    = 0;

   xadac_vdot dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req       (reqV),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp       (rspV)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic ExeReqT mkReq(input logic [7:0] id, input logic [2:0] f3,
                                    input logic [4:0] rd, input logic [31:0] acc,
                                    input logic [4:0] len, input logic [127:0] a,
                                    input logic [127:0] b);
      ExeReqT r;
      r            = '0;
      r.id         = id;
      r.instr      = {17'h0, f3, rd, 7'h0B};
      r.rs_addr[0] = 5'd3;
      r.rs_addr[1] = 5'd4;
      r.rs_data[0] = acc;
      r.rs_data[1] = {27'h5A5A5A0, len};
      r.vs_data[0] = a;
      r.vs_data[1] = b;
      r.vs_data[2] = {4{32'hDEADBEEF}};
      return r;
   endfunction

   function automatic logic [127:0] splat(input logic [7:0] v);
      return {16{v}};
   endfunction

   // One beat with no backpressure: checks 2-cycle latency and all response fields
   task automatic runOne(input string tag, input ExeReqT r, input logic [31:0] expData,
                         input logic expWrite);
      rsp_ready = 1'b1;
      reqV      = r;
      req_valid = 1'b1;
      chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
      cyc();
      req_valid = 1'b0;
      chk({tag, ".lat1"}, 64'(rsp_valid), 64'd0);
      cyc();
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, ".id"}, 64'(rspV.id), 64'(r.id));
      chk({tag, ".rd_addr"}, 64'(rspV.rd_addr), 64'(r.instr[11:7]));
      chk({tag, ".rd_data"}, 64'(rspV.rd_data), 64'(expData));
      chk({tag, ".rd_write"}, 64'(rspV.rd_write), 64'(expWrite));
      chk({tag, ".vd"}, 64'({rspV.vd_addr, rspV.vd_write, |rspV.vd_data}), 64'd0);
   endtask

   initial begin
      logic [127:0] ramp;
      logic [31:0]  held;
      logic [31:0]  expWrap;
      logic [31:0]  expSWrap;

      rst       = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      reqV      = '0;
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
      chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset.req_ready", 64'(req_ready), 64'd1);
      chk("reset.rsp", 64'({rspV.id, rspV.rd_data, rspV.rd_write}), 64'd0);

      // Unsigned, all lanes 0xFF*0xFF: 16*65025 = 0x000FE010
      runOne("u_ff", mkReq(8'h01, 3'b000, 5'd7, 32'd0, 5'd16, splat(8'hFF), splat(8'hFF)),
             32'h000F_E010, 1'b1);
      // Signed, -1*2 over 4 lanes onto 10 -> 2
      runOne("s_neg", mkReq(8'h05, 3'b001, 5'd13, 32'd10, 5'd4, splat(8'hFF), splat(8'h02)),
             32'd2, 1'b1);
      // len=0 returns acc
      runOne("len0", mkReq(8'h06, 3'b000, 5'd1, 32'h1234_5678, 5'd0, splat(8'h03), splat(8'h04)),
             32'h1234_5678, 1'b1);
      // Signed -128*-128 on 16 lanes = 0x40000; len 31 clamps to 16
      runOne("len16", mkReq(8'h07, 3'b001, 5'd2, 32'd0, 5'd16, splat(8'h80), splat(8'h80)),
             32'h0004_0000, 1'b1);
      runOne("len31", mkReq(8'h08, 3'b001, 5'd2, 32'd0, 5'd31, splat(8'h80), splat(8'h80)),
             32'h0004_0000, 1'b1);
      // Per-lane ramp a_i=i, b=2, acc=1: 1 + 2*120 = 241
      ramp = '0;
      for (int i = 0; i < 16; i++) ramp[i*8 +: 8] = 8'(i);
      runOne("ramp", mkReq(8'h09, 3'b000, 5'd31, 32'd1, 5'd16, ramp, splat(8'h02)),
             32'd241, 1'b1);
      // Ramp with len=5 keeps lanes 0..4: 1 + 2*10 = 21
      runOne("ramp5", mkReq(8'h0A, 3'b000, 5'd9, 32'd1, 5'd5, ramp, splat(8'h02)),
             32'd21, 1'b1);
      // Negative acc with signed lanes: -1 + 3*(-128) = -385
      runOne("s_acc", mkReq(8'h0B, 3'b001, 5'd4, 32'hFFFF_FFFF, 5'd3, splat(8'h80), splat(8'h01)),
             32'hFFFF_FE7F, 1'b1);
      // Illegal funct3
      runOne("illegal", mkReq(8'h0C, 3'b111, 5'd5, 32'd99, 5'd16, splat(8'h11), splat(8'h22)),
             32'd0, 1'b0);

`ifdef XADAC_VDOT_SAT_EN
      expWrap  = 32'hFFFF_FFFF;
      expSWrap = 32'h7FFF_FFFF;
`else
      expWrap  = 32'h0000_0010;
      expSWrap = 32'h8000_3EF1;
`endif
      // Unsigned 0xFFFFFFF0 + 2*16
      runOne("u_wrap", mkReq(8'h0D, 3'b000, 5'd6, 32'hFFFF_FFF0, 5'd2, splat(8'h04), splat(8'h04)),
             expWrap, 1'b1);
      // Signed 0x7FFFFFF0 + 127*127
      runOne("s_wrap", mkReq(8'h0E, 3'b001, 5'd6, 32'h7FFF_FFF0, 5'd1, splat(8'h7F), splat(8'h7F)),
             expSWrap, 1'b1);

      // Back-to-back burst of 8: beat k = acc k, a=b=k+1 on 16 lanes
      for (int t = 0; t < 10; t++) begin
         if (t >= 2) begin
            chk($sformatf("burst%0d.valid", t-2), 64'(rsp_valid), 64'd1);
            chk($sformatf("burst%0d.id", t-2), 64'(rspV.id), 64'(8'(8'h30 + t - 2)));
            chk($sformatf("burst%0d.data", t-2), 64'(rspV.rd_data),
                64'((t-2) + 16*(t-1)*(t-1)));
         end
         if (t < 8) begin
            chk($sformatf("burst%0d.req_ready", t), 64'(req_ready), 64'd1);
            reqV = mkReq(8'(8'h30 + t), 3'b000, 5'd8, 32'(t), 5'd16,
                         splat(8'(t+1)), splat(8'(t+1)));
            req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         cyc();
      end
      chk("burst.drained", 64'(rsp_valid), 64'd0);

      // Backpressure: rsp_ready low for 5 cycles with beats 20, 21, 22 offered
      rsp_ready = 1'b0;
      reqV      = mkReq(8'd20, 3'b000, 5'd10, 32'd20, 5'd16, splat(8'd21), splat(8'd21));
      req_valid = 1'b1;
      cyc();
      chk("bp.empty", 64'(rsp_valid), 64'd0);
      reqV = mkReq(8'd21, 3'b000, 5'd10, 32'd21, 5'd16, splat(8'd22), splat(8'd22));
      cyc();
      held = rspV.rd_data;
      reqV = mkReq(8'd22, 3'b000, 5'd10, 32'd22, 5'd16, splat(8'd23), splat(8'd23));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp%0d.valid", i), 64'(rsp_valid), 64'd1);
         chk($sformatf("bp%0d.id", i), 64'(rspV.id), 64'd20);
         chk($sformatf("bp%0d.data", i), 64'(rspV.rd_data), 64'd7076);
         chk($sformatf("bp%0d.stable", i), 64'(rspV.rd_data), 64'(held));
         chk($sformatf("bp%0d.req_ready", i), 64'(req_ready), 64'd0);
         if (i == 2) rsp_ready = 1'b1;
         cyc();
      end
      chk("bp.r21.id", 64'(rspV.id), 64'd21);
      chk("bp.r21.data", 64'(rspV.rd_data), 64'd7765);
      req_valid = 1'b0;
      cyc();
      chk("bp.r22.valid", 64'(rsp_valid), 64'd1);
      chk("bp.r22.id", 64'(rspV.id), 64'd22);
      chk("bp.r22.data", 64'(rspV.rd_data), 64'd8486);
      cyc();
      chk("bp.drained", 64'(rsp_valid), 64'd0);

      // Reset with two beats in flight
      reqV      = mkReq(8'd40, 3'b000, 5'd3, 32'd1, 5'd16, splat(8'h01), splat(8'h01));
      req_valid = 1'b1;
      cyc();
      reqV = mkReq(8'd41, 3'b000, 5'd3, 32'd2, 5'd16, splat(8'h01), splat(8'h01));
      cyc();
      req_valid = 1'b0;
      chk("rst.inflight", 64'(rsp_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst.async", 64'(rsp_valid), 64'd0);
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst.rsp", 64'({rspV.id, rspV.rd_data}), 64'd0);
      chk("rst.req_ready", 64'(req_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst.stale%0d", i), 64'(rsp_valid), 64'd0);
         cyc();
      end
      runOne("after_rst", mkReq(8'd42, 3'b001, 5'd12, 32'd100, 5'd2, splat(8'hFE), splat(8'h05)),
             32'd80, 1'b1);

      cyc();
      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
